// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// The optional divide-by-zero shortcut is enabled by SIGNED_DIVIDER_DIV_ZERO_DETECT_EN.
package signed_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/signed_divider_if.sv
// Level-sensitive en/ready handshake and operand/result bus of the signed divider.
interface signed_divider_if
  import signed_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             ready;
  logic             div_by_zero;

  modport master (
    output en, A, B,
    input  Quotient, Remainder, ready, div_by_zero
  );

  modport slave (
    input  en, A, B,
    output Quotient, Remainder, ready, div_by_zero
  );

endinterface

// File: rtl/signed_divider_div_step.sv
// One restoring shift-subtract step on magnitudes: shift {rem,q} left, try rem - magB.
module restoring_div_step
  import signed_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_magb,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  // The restored remainder is always below magB, so WIDTH bits hold it between steps.
  assign w_rem_sh = {i_rem, i_q[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_magb};
  assign o_rem    = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_q      = {i_q[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/signed_divider.sv
// Sequential truncating signed divider, one quotient bit per clock.
// SIGNED_DIVIDER_DIV_ZERO_DETECT_EN: B==0 completes in one edge with div_by_zero set.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            reset,
  signed_divider_if.slave bus
);

  localparam int unsigned     CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic             r_sa, w_sa_nxt;
  logic             r_sb, w_sb_nxt;
  logic [WIDTH-1:0] r_magb, w_magb_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_quot, w_quot_nxt;
  logic [WIDTH-1:0] r_remout, w_remout_nxt;
  logic             r_ready, w_ready_nxt;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
  logic             r_dbz, w_dbz_nxt;
`endif

  logic [WIDTH-1:0] w_maga;
  logic [WIDTH-1:0] w_magb;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_q;

  // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
  assign w_maga = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign w_magb = bus.B[WIDTH-1] ? -bus.B : bus.B;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_q    (r_q),
    .i_magb (r_magb),
    .o_rem  (w_step_rem),
    .o_q    (w_step_q)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_sa_nxt     = r_sa;
    w_sb_nxt     = r_sb;
    w_magb_nxt   = r_magb;
    w_rem_nxt    = r_rem;
    w_q_nxt      = r_q;
    w_cnt_nxt    = r_cnt;
    w_quot_nxt   = r_quot;
    w_remout_nxt = r_remout;
    w_ready_nxt  = r_ready;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
    w_dbz_nxt    = r_dbz;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b0;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
        w_dbz_nxt   = 1'b0;
`endif
        if (bus.en) begin
          w_sa_nxt    = bus.A[WIDTH-1];
          w_sb_nxt    = bus.B[WIDTH-1];
          w_magb_nxt  = w_magb;
          w_rem_nxt   = '0;
          w_q_nxt     = w_maga;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
          if (bus.B == '0) begin
            w_quot_nxt   = '0;
            w_remout_nxt = bus.A;
            w_dbz_nxt    = 1'b1;
            w_ready_nxt  = 1'b1;
            w_state_nxt  = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        // Dropping en aborts; the partial result is discarded, outputs keep the old result.
        if (!bus.en) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_rem_nxt = w_step_rem;
          w_q_nxt   = w_step_q;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            w_quot_nxt   = (r_sa ^ r_sb) ? -w_step_q : w_step_q;
            w_remout_nxt = r_sa ? -w_step_rem : w_step_rem;
            w_ready_nxt  = 1'b1;
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!bus.en) begin
          w_ready_nxt = 1'b0;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
          w_dbz_nxt   = 1'b0;
`endif
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_magb   <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_ready  <= 1'b0;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
      r_dbz    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sa     <= w_sa_nxt;
      r_sb     <= w_sb_nxt;
      r_magb   <= w_magb_nxt;
      r_rem    <= w_rem_nxt;
      r_q      <= w_q_nxt;
      r_cnt    <= w_cnt_nxt;
      r_quot   <= w_quot_nxt;
      r_remout <= w_remout_nxt;
      r_ready  <= w_ready_nxt;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
      r_dbz    <= w_dbz_nxt;
`endif
    end
  end

  assign bus.Quotient  = r_quot;
  assign bus.Remainder = r_remout;
  assign bus.ready     = r_ready;
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
  assign bus.div_by_zero = r_dbz;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: C-style reference, latency, abort, reset and hold checks.
module tb_signed_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  logic [7:0] last_q;
  logic [7:0] last_r;

  signed_divider_if #(.WIDTH(8)) bus ();

  signed_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ia;
    int   ib;
    int   ma;
    ia = int'($signed(a));
    ib = int'($signed(b));
    e.dbz = 1'b0;
    e.lat = 9;
    if (ib == 0) begin
`ifdef SIGNED_DIVIDER_DIV_ZERO_DETECT_EN
      e.q   = 8'h00;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
`else
      ma  = (ia < 0) ? -ia : ia;
      e.q = (a[7] ^ b[7]) ? 8'(-255) : 8'(255);
      e.r = (ia < 0) ? 8'(-ma) : 8'(ma);
`endif
    end else begin
      e.q = 8'(ia / ib);
      e.r = 8'(ia % ib);
    end
    return e;
  endfunction

  // Start a division, wait (bounded) for ready, compare against the scoreboard; en stays high.
  task automatic start_div(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   n;
    logic got;
    bus.A  = a;
    bus.B  = b;
    bus.en = 1'b1;
    sb.push_back(model(a, b));
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ready) got = 1'b1;
    end
    e = sb.pop_front();
    check("ready_seen", 32'(got), 32'(1));
    check("latency", 32'(n), 32'(e.lat));
    check("quotient", 32'(bus.Quotient), 32'(e.q));
    check("remainder", 32'(bus.Remainder), 32'(e.r));
    check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
    last_q = e.q;
    last_r = e.r;
  endtask

  task automatic release_en();
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    check("ready_fall", 32'(bus.ready), 32'(0));
    check("dbz_fall", 32'(bus.div_by_zero), 32'(0));
  endtask

  task automatic edges(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_q   = '0;
    last_r   = '0;
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.A    = '0;
    bus.B    = '0;
    edges(2);
    reset = 1'b0;
    edges(1);
    check("rst_q", 32'(bus.Quotient), 32'(0));
    check("rst_r", 32'(bus.Remainder), 32'(0));
    check("rst_ready", 32'(bus.ready), 32'(0));
    check("rst_dbz", 32'(bus.div_by_zero), 32'(0));

    // Directed operand table, including sign combinations, overflow and B=0.
    begin
      logic [7:0] ta[10] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd3, 8'd5, 8'hFB, 8'h7F};
      logic [7:0] tb[10] = '{8'd7, 8'd7, 8'hF9, 8'hF9, 8'hFF, 8'd1, 8'd10, 8'd0, 8'd0, 8'h80};
      for (int i = 0; i < 10; i++) begin
        start_div(ta[i], tb[i]);
        release_en();
      end
    end
    for (int i = 0; i < 6; i++) begin
      start_div(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
      release_en();
    end

    start_div(8'd100, 8'd7);
    check("prior_q", 32'(bus.Quotient), 32'(14));
    check("prior_r", 32'(bus.Remainder), 32'(2));
    release_en();

    // Abort after edge 4 of a new run.
    bus.A  = 8'd50;
    bus.B  = 8'd3;
    bus.en = 1'b1;
    edges(4);
    bus.en = 1'b0;
    edges(1);
    check("abort4_ready", 32'(bus.ready), 32'(0));
    edges(10);
    check("abort4_ready_late", 32'(bus.ready), 32'(0));
    check("abort4_q", 32'(bus.Quotient), 32'(14));
    check("abort4_r", 32'(bus.Remainder), 32'(2));

    // en drops on the edge that would have completed: abort wins.
    bus.en = 1'b1;
    edges(8);
    check("abort8_ready_pre", 32'(bus.ready), 32'(0));
    bus.en = 1'b0;
    edges(1);
    check("abort8_ready", 32'(bus.ready), 32'(0));
    check("abort8_q", 32'(bus.Quotient), 32'(14));
    check("abort8_r", 32'(bus.Remainder), 32'(2));

    // Asynchronous reset mid-run clears outputs before the next edge.
    bus.en = 1'b1;
    edges(3);
    reset = 1'b1;
    #1;
    check("arst_q", 32'(bus.Quotient), 32'(0));
    check("arst_r", 32'(bus.Remainder), 32'(0));
    check("arst_ready", 32'(bus.ready), 32'(0));
    check("arst_dbz", 32'(bus.div_by_zero), 32'(0));
    bus.en = 1'b0;
    edges(1);
    reset = 1'b0;
    edges(1);

    // Hold in DONE while operands toggle, then restart after one low edge.
    start_div(8'd100, 8'd7);
    for (int i = 0; i < 10; i++) begin
      bus.A = 8'($urandom_range(0, 255));
      bus.B = 8'($urandom_range(0, 255));
      edges(1);
      check("hold_ready", 32'(bus.ready), 32'(1));
      check("hold_q", 32'(bus.Quotient), 32'(last_q));
      check("hold_r", 32'(bus.Remainder), 32'(last_r));
    end
    release_en();
    start_div(8'h9C, 8'hF9);
    release_en();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
